// File: rtl/btn_pkg.sv
// Shared types and helpers for the pushbutton conditioner.
// Optional auto-repeat is enabled with BTN_AUTOREPEAT_EN.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    // Bits needed to hold 0..cycles.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchronizer, debounce counter and FSM.
// Auto-repeat logic is present only with BTN_AUTOREPEAT_EN.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_n_i,
    output logic level_n_o,
    output logic press_pulse_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1)
    begin : g_bad_param
        $error("btn_debounce_ch: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d;
    logic pulse_q, pulse_d;
    logic press;
    logic rpt_fire;
    logic p;

    assign p = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_n_i};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (p) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!p) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (p) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic entry, hold;

    assign entry = (state_d == PRESSED) && (state_q != PRESSED);
    assign hold  = (state_q == PRESSED || state_q == RELEASE_CHK)
                && (state_d != RELEASED);

    // Any entry into PRESSED restarts the repeat period.
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (!entry && hold) begin
            if (rpt_q == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign level_d = ~(state_d == PRESSED || state_d == RELEASE_CHK);
    assign pulse_d = press | rpt_fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_n_o     = level_q;
    assign press_pulse_o = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Synchronizes and debounces active-low pushbuttons for the SLC-3.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat pulses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] btn_raw_n,
    output logic [NUM_BTN-1:0] btn_level_n,
    output logic [NUM_BTN-1:0] btn_press_pulse
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk_i         (Clk),
            .rst_i         (Reset),
            .raw_n_i       (btn_raw_n[i]),
            .level_n_o     (btn_level_n[i]),
            .press_pulse_o (btn_press_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner; expectations follow
// BTN_AUTOREPEAT_EN when it is defined.
module tb_btn_conditioner;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] btn_raw_n = 3'b111;
    logic [2:0] btn_level_n;
    logic [2:0] btn_press_pulse;

    typedef struct {
        string      tag;
        logic [2:0] lvl;
        logic [2:0] pls;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    btn_conditioner #(
        .NUM_BTN         (3),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .btn_raw_n       (btn_raw_n),
        .btn_level_n     (btn_level_n),
        .btn_press_pulse (btn_press_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        n_chk++;
        assert ({btn_level_n, btn_press_pulse} === {e.lvl, e.pls})
        else begin
            n_fail++;
            $error("FAIL %s: level=%b pulse=%b, expected level=%b pulse=%b",
                   e.tag, btn_level_n, btn_press_pulse, e.lvl, e.pls);
        end
    endtask

    // Drive raw for the next edge, then check outputs after it.
    task automatic cyc(input logic [2:0] raw, input string tag,
                       input logic [2:0] lvl, input logic [2:0] pls);
        exp_t e;
        btn_raw_n = raw;
        e.tag = tag;
        e.lvl = lvl;
        e.pls = pls;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        compare_front();
    endtask

    task automatic now(input string tag,
                       input logic [2:0] lvl, input logic [2:0] pls);
        exp_t e;
        e.tag = tag;
        e.lvl = lvl;
        e.pls = pls;
        sb.push_back(e);
        #1;
        compare_front();
    endtask

    initial begin
        logic [2:0] raw;
        logic [2:0] lvl;
        logic [2:0] pls;

        for (int i = 0; i < 3; i++)
            cyc(3'b111, $sformatf("rst_idle[%0d]", i), 3'b111, 3'b000);
        for (int i = 0; i < 4; i++)
            cyc(3'b000, $sformatf("rst_forced[%0d]", i), 3'b111, 3'b000);
        cyc(3'b111, "rst_restore", 3'b111, 3'b000);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++)
            cyc(3'b111, $sformatf("idle[%0d]", i), 3'b111, 3'b000);

        for (int i = 0; i <= 6; i++)
            cyc(3'b101, $sformatf("press1[%0d]", i),
                (i >= 6) ? 3'b101 : 3'b111,
                (i == 6) ? 3'b010 : 3'b000);
        for (int i = 0; i <= 7; i++)
            cyc(3'b111, $sformatf("release1[%0d]", i),
                (i >= 6) ? 3'b111 : 3'b101, 3'b000);

        for (int i = 0; i < 3; i++)
            cyc(3'b110, $sformatf("bounce0[%0d]", i), 3'b111, 3'b000);
        for (int i = 0; i < 6; i++)
            cyc(3'b111, $sformatf("bounce0_end[%0d]", i), 3'b111, 3'b000);
        for (int i = 0; i < 20; i++)
            cyc((i % 2 == 1) ? 3'b111 : 3'b110, $sformatf("glitch0[%0d]", i),
                3'b111, 3'b000);
        for (int i = 0; i < 6; i++)
            cyc(3'b111, $sformatf("glitch0_end[%0d]", i), 3'b111, 3'b000);

        for (int i = 0; i <= 6; i++)
            cyc(3'b000, $sformatf("press_all[%0d]", i),
                (i >= 6) ? 3'b000 : 3'b111,
                (i == 6) ? 3'b111 : 3'b000);
        for (int i = 0; i <= 7; i++)
            cyc(3'b111, $sformatf("release_all[%0d]", i),
                (i >= 6) ? 3'b111 : 3'b000, 3'b000);

        for (int i = 0; i <= 22; i++) begin
            if (i <= 7 || i == 10 || i == 11) raw = 3'b011;
            else raw = 3'b111;
            if (i < 6 || i >= 18) lvl = 3'b111;
            else lvl = 3'b011;
            pls = (i == 6) ? 3'b100 : 3'b000;
            cyc(raw, $sformatf("ch2_glitch[%0d]", i), lvl, pls);
        end

        for (int i = 0; i <= 4; i++)
            cyc(3'b110, $sformatf("mid_deb[%0d]", i), 3'b111, 3'b000);
        Reset = 1'b1;
        now("rst_mid", 3'b111, 3'b000);
        for (int i = 0; i < 3; i++)
            cyc(3'b110, $sformatf("rst_hold[%0d]", i), 3'b111, 3'b000);
        Reset = 1'b0;
        for (int i = 0; i <= 6; i++)
            cyc(3'b110, $sformatf("fresh0[%0d]", i),
                (i >= 6) ? 3'b110 : 3'b111,
                (i == 6) ? 3'b001 : 3'b000);

        for (int i = 7; i <= 36; i++) begin
`ifdef BTN_AUTOREPEAT_EN
            pls = ((i - 6) % 8 == 0) ? 3'b001 : 3'b000;
`else
            pls = 3'b000;
`endif
            cyc(3'b110, $sformatf("hold0[%0d]", i), 3'b110, pls);
        end

        Reset = 1'b1;
        now("rst_async", 3'b111, 3'b000);
        cyc(3'b110, "rst_async_hold", 3'b111, 3'b000);
        cyc(3'b111, "rst_async_rel", 3'b111, 3'b000);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(3'b111, $sformatf("final_idle[%0d]", i), 3'b111, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
